// File: rtl/lm32_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read address.
// Read data is driven combinationally from the array at the latched address.
module lm32_sdp_ram #(
  parameter int data_width    = 1,
  parameter int address_width = 1
) (
  input  logic                     read_clk,
  input  logic                     write_clk,
  input  logic                     reset,
  input  logic [address_width-1:0] read_address,
  input  logic                     enable_read,
  input  logic [address_width-1:0] write_address,
  input  logic                     enable_write,
  input  logic                     write_enable,
  input  logic [data_width-1:0]    write_data,
  output logic [data_width-1:0]    read_data
);

  localparam int Depth = 1 << address_width;

  logic [data_width-1:0]    r_mem [0:Depth-1] = '{default: '0};
  logic [address_width-1:0] r_ra;
  logic                     w_wr;

  assign w_wr = enable_write & write_enable;

  always_ff @(posedge read_clk) begin
    if (reset)
      r_ra <= '0;
    else if (enable_read)
      r_ra <= read_address;
  end

  // The write port ignores reset so stored contents survive it.
  always_ff @(posedge write_clk) begin
    if (w_wr)
      r_mem[write_address] <= write_data;
  end

  assign read_data = r_mem[r_ra];

endmodule

// File: tb/tb_lm32_sdp_ram.sv
// Randomized and directed checks of lm32_sdp_ram against a behavioural model.
// A second instance covers wide words and a deep array.
module tb_lm32_sdp_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       er = 1'b0, ew = 1'b0, we = 1'b0;
  logic [3:0] ra_in = '0, wa = '0;
  logic [7:0] wd = '0;
  logic [7:0] rd;

  logic        b_er = 1'b0, b_ew = 1'b0, b_we = 1'b0;
  logic [9:0]  b_ra = '0, b_wa = '0;
  logic [40:0] b_wd = '0;
  logic [40:0] b_rd;

  lm32_sdp_ram #(.data_width(8), .address_width(4)) dut (
    .read_clk(clk), .write_clk(clk), .reset(reset),
    .read_address(ra_in), .enable_read(er),
    .write_address(wa), .enable_write(ew), .write_enable(we),
    .write_data(wd), .read_data(rd)
  );

  lm32_sdp_ram #(.data_width(41), .address_width(10)) dut_w (
    .read_clk(clk), .write_clk(clk), .reset(reset),
    .read_address(b_ra), .enable_read(b_er),
    .write_address(b_wa), .enable_write(b_ew), .write_enable(b_we),
    .write_data(b_wd), .read_data(b_rd)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_mem [16];
  int         m_ra;

  task automatic check(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, advance the model.
  task automatic cyc(input logic r, input logic e_r, input logic [3:0] a,
                     input logic e_w, input logic w_e,
                     input logic [3:0] waddr, input logic [7:0] d);
    reset = r; er = e_r; ra_in = a;
    ew = e_w; we = w_e; wa = waddr; wd = d;
    @(posedge clk);
    if (r) m_ra = 0;
    else if (e_r) m_ra = int'(a);
    if (e_w && w_e) m_mem[waddr] = d;
    #1;
  endtask

  always @(negedge clk)
    if (chk_en) check("model", {56'd0, rd}, {56'd0, m_mem[m_ra]});

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ra = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("reset_out", {56'd0, rd}, 64'h0);

    for (int a = 0; a < 16; a++) begin
      cyc(0, 1, a[3:0], 0, 0, 0, 0);
      check("init_zero", {56'd0, rd}, 64'h0);
    end

    cyc(0, 0, 0, 1, 1, 4'd3, 8'hA5);
    cyc(0, 1, 4'd3, 0, 0, 0, 0);
    check("read_a5", {56'd0, rd}, 64'hA5);

    cyc(0, 0, 4'd7, 1, 1, 4'd7, 8'h11);
    check("hold_w", {56'd0, rd}, 64'hA5);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 4'd7, 0, 0, 0, 0);
      check("hold", {56'd0, rd}, 64'hA5);
    end
    cyc(0, 1, 4'd7, 0, 0, 0, 0);
    check("read_11", {56'd0, rd}, 64'h11);

    cyc(0, 1, 4'd5, 1, 1, 4'd5, 8'h3C);
    check("wr_first", {56'd0, rd}, 64'h3C);
    cyc(0, 0, 4'd5, 0, 1, 4'd5, 8'h77);
    check("no_ew", {56'd0, rd}, 64'h3C);
    cyc(0, 0, 4'd5, 1, 0, 4'd5, 8'h77);
    check("no_we", {56'd0, rd}, 64'h3C);
    cyc(0, 0, 4'd5, 1, 1, 4'd5, 8'h66);
    check("late_wr", {56'd0, rd}, 64'h66);

    cyc(0, 0, 0, 1, 1, 4'd0, 8'hEE);
    cyc(0, 1, 4'd9, 1, 1, 4'd9, 8'h42);
    check("read_42", {56'd0, rd}, 64'h42);
    cyc(1, 1, 4'd9, 0, 0, 0, 0);
    check("rst_mem0", {56'd0, rd}, 64'hEE);
    cyc(0, 1, 4'd9, 0, 0, 0, 0);
    check("mem9_kept", {56'd0, rd}, 64'h42);
    cyc(1, 0, 0, 1, 1, 4'd0, 8'h5A);
    check("rst_wr", {56'd0, rd}, 64'h5A);

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 19) == 0, 1'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
    end

    b_ew = 1; b_we = 1; b_wa = 10'd1023; b_wd = '1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    b_wa = 10'd0; b_wd = 41'h0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    b_wa = 10'd512; b_wd = 41'h155_5555_5555;
    cyc(0, 0, 0, 0, 0, 0, 0);
    b_ew = 0; b_we = 0; b_er = 1; b_ra = 10'd1023;
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("w_ones", {23'd0, b_rd}, 64'h1FF_FFFF_FFFF);
    b_ra = 10'd0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("w_zero", {23'd0, b_rd}, 64'h0);
    b_ra = 10'd512;
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("w_alt", {23'd0, b_rd}, 64'h155_5555_5555);
    b_ra = 10'd511;
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("w_init", {23'd0, b_rd}, 64'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
